// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer
// -----------------------------------------------------------------------------
// Sequencing controller for one or more LIFCL PLL_CORE instances. Each channel
// runs its own FSM (STDBY, RESET, WAIT, LOCKED, FAULT). The FSM holds PLLRESET
// for a fixed number of cycles and then waits for a filtered, synchronised
// LOCK. It retries after a lock timeout and parks in FAULT once the retry
// budget is spent. Every output is registered from the next-state values, so
// an output changes on the same edge as the state change that causes it.
//
// Optional build macro: PLL_SEQ_STAGGER_EN
//   When defined, channel i>0 is held in RESET after its reset time expires
//   until channel i-1 is LOCKED or in STDBY. When undefined, all channels
//   sequence independently.
//
// Ports:
//   clk        in   1      system clock
//   rst        in   1      synchronous, active-high reset
//   stdby_req  in   N_PLL  per-channel standby request (level)
//   retry_req  in   N_PLL  per-channel single-cycle pulse, leaves FAULT
//   pll_lock   in   N_PLL  raw LOCK from PLL_CORE (asynchronous)
//   pll_reset  out  N_PLL  to PLL_CORE PLLRESET
//   pll_stdby  out  N_PLL  to PLL_CORE STDBY
//   ready      out  N_PLL  channel locked and filtered
//   fault      out  N_PLL  channel exhausted its retries
//   lol_pulse  out  N_PLL  one-cycle pulse on loss of lock from LOCKED
//   all_ready  out  1      AND of ready over non-standby channels (0 if all
//                          channels are in standby)
//   state_dbg  out  3*N_PLL  per-channel FSM state, channel i at [3*i +: 3]
// -----------------------------------------------------------------------------
module pll_lock_sequencer #(
    parameter int N_PLL        = 1,
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_FILTER  = 32,
    parameter int LOCK_TIMEOUT = 4096,
    parameter int MAX_RETRY    = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_PLL-1:0]   stdby_req,
    input  logic [N_PLL-1:0]   retry_req,
    input  logic [N_PLL-1:0]   pll_lock,
    output logic [N_PLL-1:0]   pll_reset,
    output logic [N_PLL-1:0]   pll_stdby,
    output logic [N_PLL-1:0]   ready,
    output logic [N_PLL-1:0]   fault,
    output logic [N_PLL-1:0]   lol_pulse,
    output logic               all_ready,
    output logic [3*N_PLL-1:0] state_dbg
);

    localparam int CNT_MAX = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int FW      = $clog2(LOCK_FILTER + 1);
    localparam int RW      = $clog2(MAX_RETRY + 1);

    // Counters start at 0 on state entry, so the "last" values mark the final
    // cycle of each interval.
    localparam logic [CW-1:0] RST_LAST  = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] TMO_LAST  = CW'(LOCK_TIMEOUT - 1);
    localparam logic [FW-1:0] FLT_LAST  = FW'(LOCK_FILTER - 1);
    localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRY);

    typedef enum logic [2:0] {
        ST_STDBY  = 3'd0,
        ST_RESET  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_LOCKED = 3'd3,
        ST_FAULT  = 3'd4
    } state_t;

    state_t          state_q [N_PLL];
    state_t          state_d [N_PLL];
    logic [CW-1:0]   cnt_q   [N_PLL];
    logic [CW-1:0]   cnt_d   [N_PLL];
    logic [FW-1:0]   filt_q  [N_PLL];
    logic [FW-1:0]   filt_d  [N_PLL];
    logic [RW-1:0]   retry_q [N_PLL];
    logic [RW-1:0]   retry_d [N_PLL];

    logic [N_PLL-1:0] sync1_q;
    logic [N_PLL-1:0] lock_s;
    logic [N_PLL-1:0] release_ok;
    logic [N_PLL-1:0] reset_d, stdby_d, ready_d, fault_d, lol_d;
    logic             all_ready_d;

    // Per-channel permission to leave RESET once its reset time has expired.
    for (genvar g = 0; g < N_PLL; g++) begin : g_chan
`ifdef PLL_SEQ_STAGGER_EN
        if (g == 0) begin : g_first
            assign release_ok[g] = 1'b1;
        end else begin : g_chain
            // Only the current state of the previous channel matters: a later
            // loss of lock there never pulls this channel back.
            assign release_ok[g] = (state_q[g-1] == ST_LOCKED) ||
                                   (state_q[g-1] == ST_STDBY);
        end
`else
        assign release_ok[g] = 1'b1;
`endif
        assign state_dbg[3*g +: 3] = state_q[g];
    end

    always_comb begin
        for (int i = 0; i < N_PLL; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            filt_d[i]  = filt_q[i];
            retry_d[i] = retry_q[i];
            lol_d[i]   = 1'b0;

            if (stdby_req[i]) begin
                state_d[i] = ST_STDBY;
                cnt_d[i]   = '0;
                filt_d[i]  = '0;
            end else begin
                case (state_q[i])
                    ST_STDBY: begin
                        state_d[i] = ST_RESET;
                        cnt_d[i]   = '0;
                        retry_d[i] = '0;
                    end
                    ST_RESET: begin
                        filt_d[i] = '0;
                        if (cnt_q[i] == RST_LAST) begin
                            // Counter parks at RST_LAST while a stagger hold applies.
                            if (release_ok[i]) begin
                                state_d[i] = ST_WAIT;
                                cnt_d[i]   = '0;
                            end
                        end else begin
                            cnt_d[i] = cnt_q[i] + CW'(1);
                        end
                    end
                    ST_WAIT: begin
                        // Filter completion is checked first so it wins a tie
                        // with the timeout.
                        if (lock_s[i] && (filt_q[i] == FLT_LAST)) begin
                            state_d[i] = ST_LOCKED;
                            cnt_d[i]   = '0;
                            filt_d[i]  = '0;
                            retry_d[i] = '0;
                        end else if (cnt_q[i] == TMO_LAST) begin
                            cnt_d[i]  = '0;
                            filt_d[i] = '0;
                            if ((retry_q[i] + RW'(1)) >= RETRY_LIM) begin
                                state_d[i] = ST_FAULT;
                                retry_d[i] = RETRY_LIM;
                            end else begin
                                state_d[i] = ST_RESET;
                                retry_d[i] = retry_q[i] + RW'(1);
                            end
                        end else begin
                            cnt_d[i]  = cnt_q[i] + CW'(1);
                            filt_d[i] = lock_s[i] ? (filt_q[i] + FW'(1)) : '0;
                        end
                    end
                    ST_LOCKED: begin
                        // Loss of lock restarts the channel without touching
                        // the retry budget.
                        if (!lock_s[i]) begin
                            state_d[i] = ST_RESET;
                            cnt_d[i]   = '0;
                            lol_d[i]   = 1'b1;
                        end
                    end
                    ST_FAULT: begin
                        if (retry_req[i]) begin
                            state_d[i] = ST_RESET;
                            cnt_d[i]   = '0;
                            retry_d[i] = '0;
                        end
                    end
                    default: begin
                        state_d[i] = ST_RESET;
                        cnt_d[i]   = '0;
                        filt_d[i]  = '0;
                        retry_d[i] = '0;
                    end
                endcase
            end

            reset_d[i] = (state_d[i] == ST_RESET) || (state_d[i] == ST_STDBY) ||
                         (state_d[i] == ST_FAULT);
            stdby_d[i] = (state_d[i] == ST_STDBY);
            ready_d[i] = (state_d[i] == ST_LOCKED);
            fault_d[i] = (state_d[i] == ST_FAULT);
        end

        all_ready_d = (&(ready_d | stdby_d)) & ~(&stdby_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            lock_s  <= '0;
            for (int i = 0; i < N_PLL; i++) begin
                state_q[i] <= ST_RESET;
                cnt_q[i]   <= '0;
                filt_q[i]  <= '0;
                retry_q[i] <= '0;
            end
            pll_reset <= '1;
            pll_stdby <= '0;
            ready     <= '0;
            fault     <= '0;
            lol_pulse <= '0;
            all_ready <= 1'b0;
        end else begin
            sync1_q <= pll_lock;
            lock_s  <= sync1_q;
            for (int i = 0; i < N_PLL; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
                filt_q[i]  <= filt_d[i];
                retry_q[i] <= retry_d[i];
            end
            pll_reset <= reset_d;
            pll_stdby <= stdby_d;
            ready     <= ready_d;
            fault     <= fault_d;
            lol_pulse <= lol_d;
            all_ready <= all_ready_d;
        end
    end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb_pll_lock_sequencer
// -----------------------------------------------------------------------------
// Self-checking bench for pll_lock_sequencer (N_PLL=2, RST_CYCLES=4,
// LOCK_FILTER=8, LOCK_TIMEOUT=64, MAX_RETRY=2). A cycle-level reference model
// tracks each channel as a mode plus elapsed-time and lock-run counts. All
// outputs are compared against it on every falling edge. Directed steps add
// fixed-value checks for latency, pulse counts and reset values. These are
// followed by a randomized phase.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pll_lock_sequencer;

    localparam int N  = 2;
    localparam int RC = 4;
    localparam int LF = 8;
    localparam int TO = 64;
    localparam int MR = 2;

`ifdef PLL_SEQ_STAGGER_EN
    localparam bit STAGGER = 1'b1;
`else
    localparam bit STAGGER = 1'b0;
`endif

    localparam int M_OFF = 0, M_RST = 1, M_WAIT = 2, M_LOCK = 3, M_FLT = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0]   stdby_req = '0;
    logic [N-1:0]   retry_req = '0;
    logic [N-1:0]   pll_lock  = '0;
    logic [N-1:0]   pll_reset, pll_stdby, ready, fault, lol_pulse;
    logic           all_ready;
    logic [3*N-1:0] state_dbg;

    int checks   = 0;
    int failures = 0;

    pll_lock_sequencer #(
        .N_PLL        (N),
        .RST_CYCLES   (RC),
        .LOCK_FILTER  (LF),
        .LOCK_TIMEOUT (TO),
        .MAX_RETRY    (MR)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .stdby_req (stdby_req),
        .retry_req (retry_req),
        .pll_lock  (pll_lock),
        .pll_reset (pll_reset),
        .pll_stdby (pll_stdby),
        .ready     (ready),
        .fault     (fault),
        .lol_pulse (lol_pulse),
        .all_ready (all_ready),
        .state_dbg (state_dbg)
    );

    // ---------------- reference model ----------------
    int md    [N];
    int age   [N];
    int run   [N];
    int fails [N];
    logic [N-1:0] h1 = '0, h2 = '0;
    logic [N-1:0] m_reset = '1, m_stdby = '0, m_ready = '0, m_fault = '0, m_lol = '0;
    logic         m_all = 1'b0;

    always @(posedge clk) begin
        logic [N-1:0] ls;
        int  prev [N];
        bit  gate;
        bit  any_live, all_good;
        if (rst) begin
            for (int c = 0; c < N; c++) begin
                md[c] = M_RST; age[c] = 0; run[c] = 0; fails[c] = 0;
            end
            h1 = '0; h2 = '0;
            m_reset = '1; m_stdby = '0; m_ready = '0; m_fault = '0; m_lol = '0;
            m_all = 1'b0;
        end else begin
            // lock as seen by the decisions is pll_lock from two edges ago
            ls = h2; h2 = h1; h1 = pll_lock;
            for (int c = 0; c < N; c++) prev[c] = md[c];
            m_lol = '0;
            for (int c = 0; c < N; c++) begin
                gate = !STAGGER || (c == 0) ||
                       (prev[(c == 0) ? 0 : c - 1] == M_LOCK) ||
                       (prev[(c == 0) ? 0 : c - 1] == M_OFF);
                if (stdby_req[c]) begin
                    md[c] = M_OFF; age[c] = 0; run[c] = 0;
                end else if (md[c] == M_OFF) begin
                    md[c] = M_RST; age[c] = 0; fails[c] = 0;
                end else if (md[c] == M_RST) begin
                    if ((age[c] + 1 >= RC) && gate) begin
                        md[c] = M_WAIT; age[c] = 0; run[c] = 0;
                    end else begin
                        age[c] = (age[c] + 1 >= RC) ? RC : age[c] + 1;
                    end
                end else if (md[c] == M_WAIT) begin
                    age[c] = age[c] + 1;
                    run[c] = ls[c] ? run[c] + 1 : 0;
                    if (run[c] >= LF) begin
                        md[c] = M_LOCK; fails[c] = 0;
                    end else if (age[c] >= TO) begin
                        fails[c] = fails[c] + 1;
                        md[c] = (fails[c] >= MR) ? M_FLT : M_RST;
                        age[c] = 0;
                    end
                end else if (md[c] == M_LOCK) begin
                    if (!ls[c]) begin
                        md[c] = M_RST; age[c] = 0; m_lol[c] = 1'b1;
                    end
                end else if (md[c] == M_FLT) begin
                    if (retry_req[c]) begin
                        md[c] = M_RST; age[c] = 0; fails[c] = 0;
                    end
                end
            end
            any_live = 1'b0;
            all_good = 1'b1;
            for (int c = 0; c < N; c++) begin
                m_reset[c] = (md[c] == M_RST) || (md[c] == M_OFF) || (md[c] == M_FLT);
                m_stdby[c] = (md[c] == M_OFF);
                m_ready[c] = (md[c] == M_LOCK);
                m_fault[c] = (md[c] == M_FLT);
                if (md[c] != M_OFF) begin
                    any_live = 1'b1;
                    if (md[c] != M_LOCK) all_good = 1'b0;
                end
            end
            m_all = any_live && all_good;
        end
    end

    // ---------------- scoreboard helpers ----------------
    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0b expected=%0b at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance n cycles; compare every output with the model on each falling edge.
    task automatic cyc(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            chk("pll_reset", 8'(pll_reset), 8'(m_reset));
            chk("pll_stdby", 8'(pll_stdby), 8'(m_stdby));
            chk("ready",     8'(ready),     8'(m_ready));
            chk("fault",     8'(fault),     8'(m_fault));
            chk("lol_pulse", 8'(lol_pulse), 8'(m_lol));
            chk("all_ready", 8'(all_ready), 8'(m_all));
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_pll_reset"}, 8'(pll_reset), 8'(2'b11));
        chk({tag, "_pll_stdby"}, 8'(pll_stdby), 8'd0);
        chk({tag, "_ready"},     8'(ready),     8'd0);
        chk({tag, "_fault"},     8'(fault),     8'd0);
        chk({tag, "_lol"},       8'(lol_pulse), 8'd0);
        chk({tag, "_all_ready"}, 8'(all_ready), 8'd0);
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        int   n, falls, highs, lol_cnt, lol_at, rate;
        logic prev_r;

        // reset, channel 1 parked in standby
        stdby_req = 2'b10;
        repeat (3) @(posedge clk);
        cyc(1);
        chk_reset_values("rst");

        // basic lock on channel 0
        rst = 1'b0;
        cyc(12);
        chk("ch1_in_stdby", 8'(pll_stdby), 8'(2'b10));
        pll_lock[0] = 1'b1;
        cyc(LF + 1);
        chk("lock_not_early", 8'(ready[0]), 8'd0);
        cyc(1);
        chk("lock_latency", 8'(ready[0]), 8'd1);
        chk("all_ready_ch0_only", 8'(all_ready), 8'd1);

        // one-cycle loss of lock
        pll_lock[0] = 1'b0;
        cyc(1);
        pll_lock[0] = 1'b1;
        lol_cnt = 0; lol_at = -1; highs = 0;
        for (int k = 2; k <= 12; k++) begin
            cyc(1);
            if (lol_pulse[0] === 1'b1) begin
                lol_cnt++;
                if (lol_at < 0) lol_at = k;
            end
            if (pll_reset[0] === 1'b1) highs++;
        end
        chk("lol_count", 8'(lol_cnt), 8'd1);
        chk("lol_position", 8'(lol_at), 8'd3);
        chk("lol_reset_len", 8'(highs), 8'(RC));
        n = 0;
        while (ready[0] !== 1'b1 && n < 50) begin cyc(1); n++; end
        chk("relock_ready", 8'(ready[0]), 8'd1);
        chk("relock_no_fault", 8'(fault), 8'd0);

        // glitch filter: high 5, low 1, high again while in WAIT
        pll_lock[0] = 1'b0;
        cyc(10);
        pll_lock[0] = 1'b1;
        cyc(5);
        pll_lock[0] = 1'b0;
        cyc(1);
        pll_lock[0] = 1'b1;
        cyc(LF + 1);
        chk("glitch_not_early", 8'(ready[0]), 8'd0);
        cyc(1);
        chk("glitch_latency", 8'(ready[0]), 8'd1);

        // retries exhausted -> FAULT
        pll_lock[0] = 1'b0;
        falls = 0; prev_r = pll_reset[0]; n = 0;
        while (fault[0] !== 1'b1 && n < 400) begin
            cyc(1); n++;
            if (prev_r && !pll_reset[0]) falls++;
            prev_r = pll_reset[0];
        end
        chk("fault_reached", 8'(fault[0]), 8'd1);
        chk("fault_reset_pulses", 8'(falls), 8'd2);
        chk("fault_pll_reset", 8'(pll_reset[0]), 8'd1);
        cyc(20);
        chk("fault_sticky", 8'(fault[0]), 8'd1);

        // retry_req leaves FAULT (and is ignored by the standby channel)
        retry_req = 2'b11;
        cyc(1);
        retry_req = 2'b00;
        chk("retry_clears_fault", 8'(fault[0]), 8'd0);
        chk("retry_ch1_still_stdby", 8'(pll_stdby[1]), 8'd1);
        highs = 0; n = 0;
        while (pll_reset[0] === 1'b1 && n < 20) begin highs++; cyc(1); n++; end
        chk("retry_reset_len", 8'(highs), 8'(RC));

        // bring channel 1 out of standby, both lock
        pll_lock  = 2'b11;
        stdby_req = 2'b00;
        n = 0;
        while (all_ready !== 1'b1 && n < 120) begin cyc(1); n++; end
        chk("both_ready", 8'(ready), 8'(2'b11));
        chk("both_all_ready", 8'(all_ready), 8'd1);

        // channel 1 back to standby: all_ready follows channel 0 alone
        stdby_req = 2'b10;
        cyc(1);
        chk("stdby1_pll_stdby", 8'(pll_stdby), 8'(2'b10));
        chk("stdby1_pll_reset", 8'(pll_reset[1]), 8'd1);
        chk("stdby1_all_ready", 8'(all_ready), 8'd1);
        pll_lock[0] = 1'b0;
        cyc(4);
        chk("stdby1_ch0_lost", 8'(all_ready), 8'd0);
        pll_lock[0] = 1'b1;
        stdby_req = 2'b11;
        cyc(1);
        chk("all_stdby_all_ready", 8'(all_ready), 8'd0);
        chk("all_stdby_pll_stdby", 8'(pll_stdby), 8'(2'b11));

        // rst asserted while in WAIT
        stdby_req = 2'b00;
        cyc(7);
        rst = 1'b1;
        cyc(1);
        chk_reset_values("mid_rst");
        rst = 1'b0;

        // randomized phase
        for (int blk = 0; blk < 8; blk++) begin
            rate = $urandom_range(8, 60);
            for (int k = 0; k < 500; k++) begin
                for (int c = 0; c < N; c++) begin
                    if ($urandom_range(0, rate) == 0) pll_lock[c] = ~pll_lock[c];
                    if ($urandom_range(0, 399) == 0) stdby_req[c] = ~stdby_req[c];
                    retry_req[c] = ($urandom_range(0, 49) == 0);
                end
                rst = ($urandom_range(0, 1499) == 0);
                cyc(1);
            end
        end
        rst = 1'b0;
        retry_req = '0;
        cyc(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
